// File: rtl/reorder_pkg.sv
// Shared constants, FSM state type and width helpers for the scatter-accumulate block.
package reorder_pkg;

    localparam int LANES_DEF     = 9;
    localparam int DW_DEF        = 8;
    localparam int AW_DEF        = 16;
    localparam int FRAME_LEN_DEF = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // ceil(log2(v)) with a one-bit floor so single-valued fields still exist
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scatter_bin_sum.sv
// Combinational masked sum of every lane whose index selects bin BIN_ID.
module scatter_bin_sum #(
    parameter int LANES  = 9,
    parameter int DW     = 8,
    parameter int IW     = 4,
    parameter int SW     = 12,
    parameter int BIN_ID = 0
) (
    input  logic [LANES*DW-1:0] i_data,
    input  logic [LANES*IW-1:0] i_index,
    output logic [SW-1:0]       o_sum
);

    // accumulate all matching lanes; several lanes may target the same bin
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_index[i*IW +: IW] == IW'(BIN_ID)) begin
                o_sum = o_sum + SW'(i_data[i*DW +: DW]);
            end else begin
                o_sum = o_sum;
            end
        end
    end

endmodule

// File: rtl/reorder_scatter_accum.sv
// Streaming scatter-accumulate: per-beat lane scatter into LANES bins, frame result over valid/ready.
// Optional build macro SCATTER_SATURATE_EN: bins clamp at all-ones instead of wrapping.
module reorder_scatter_accum
    import reorder_pkg::*;
#(
    parameter int  LANES     = LANES_DEF,
    parameter int  DW        = DW_DEF,
    parameter int  AW        = AW_DEF,
    parameter int  FRAME_LEN = FRAME_LEN_DEF,
    localparam int IW        = clog2_min1(LANES),
    localparam int BW        = clog2_min1(FRAME_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES*IW-1:0] in_index,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*AW-1:0] out_data,
    output logic [BW-1:0]       out_beats,
    output logic [LANES-1:0]    out_ovf,
    output logic                idx_err
);

    localparam int SW = DW + clog2_min1(LANES);
    // the add is done wide enough that any excess above AW bits is visible as overflow
    localparam int XW = max_int(AW, SW) + 1;

    state_e                   r_state;
    state_e                   w_state_next;
    logic                     r_bubble;
    logic [LANES-1:0][AW-1:0] r_bin;
    logic [LANES-1:0]         r_ovf;
    logic [BW-1:0]            r_count;
    logic [LANES*AW-1:0]      r_out_data;
    logic [BW-1:0]            r_out_beats;
    logic [LANES-1:0]         r_out_ovf;
    logic                     r_idx_err;

    logic [LANES-1:0][SW-1:0] w_sum;
    logic [LANES-1:0][XW-1:0] w_add;
    logic [LANES-1:0]         w_carry;
    logic [LANES-1:0][AW-1:0] w_bin_next;
    logic [LANES-1:0]         w_ovf_next;
    logic                     w_accept;
    logic                     w_close;
    logic                     w_idx_bad;
    logic                     w_in_ready;
    logic                     w_out_valid;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_bin
            scatter_bin_sum #(
                .LANES (LANES),
                .DW    (DW),
                .IW    (IW),
                .SW    (SW),
                .BIN_ID(g)
            ) u_bin_sum (
                .i_data (in_data),
                .i_index(in_index),
                .o_sum  (w_sum[g])
            );
        end
    endgenerate

    // per-bin update value and sticky overflow including the current beat
    always_comb begin
        w_add      = '0;
        w_carry    = '0;
        w_bin_next = '0;
        w_ovf_next = '0;
        for (int j = 0; j < LANES; j++) begin
            w_add[j]   = XW'(r_bin[j]) + XW'(w_sum[j]);
            w_carry[j] = |w_add[j][XW-1:AW];
`ifdef SCATTER_SATURATE_EN
            w_bin_next[j] = w_carry[j] ? {AW{1'b1}} : w_add[j][AW-1:0];
`else
            w_bin_next[j] = w_add[j][AW-1:0];
`endif
            w_ovf_next[j] = r_ovf[j] | w_carry[j];
        end
    end

    // any lane pointing past the last bin is dropped and flagged
    always_comb begin
        w_idx_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(in_index[i*IW +: IW]) >= LANES) begin
                w_idx_bad = 1'b1;
            end else begin
                w_idx_bad = w_idx_bad;
            end
        end
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_close  = (r_count == BW'(FRAME_LEN - 1)) || in_last;

    // FSM state register; r_bubble blocks input for one cycle after a release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ACCUM;
            r_bubble <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bubble <= (r_state == HOLD) && out_ready;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: begin
                if (w_accept && w_close) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = ACCUM;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready  = !r_bubble;
                w_out_valid = 1'b0;
            end
            HOLD: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // bins, beat count and the held frame result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin       <= '0;
            r_ovf       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= '0;
            r_idx_err   <= 1'b0;
        end else begin
            r_idx_err <= w_accept && w_idx_bad;
            if (w_accept && w_close) begin
                r_out_data  <= w_bin_next;
                r_out_beats <= r_count + BW'(1);
                r_out_ovf   <= w_ovf_next;
                r_bin       <= '0;
                r_ovf       <= '0;
                r_count     <= '0;
            end else if (w_accept) begin
                r_bin   <= w_bin_next;
                r_ovf   <= w_ovf_next;
                r_count <= r_count + BW'(1);
            end else begin
                r_bin   <= r_bin;
                r_ovf   <= r_ovf;
                r_count <= r_count;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;
    assign idx_err   = r_idx_err;

endmodule
